// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins and key-event handshake between the scanner and its consumer.
`timescale 1ns/1ps
interface keypad_scanner_if;
    logic [3:0] o_col;
    logic [3:0] i_row;
    logic [3:0] o_key_code;
    logic       o_key_valid;
    logic       i_key_ready;
    logic       o_key_pressed;
    logic       o_overflow;
    logic       i_clr_overflow;

    modport master (
        output o_col, o_key_code, o_key_valid, o_key_pressed, o_overflow,
        input  i_row, i_key_ready, i_clr_overflow
    );

    modport slave (
        input  o_col, o_key_code, o_key_valid, o_key_pressed, o_overflow,
        output i_row, i_key_ready, i_clr_overflow
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row synchroniser, scan-level
// debounce with ghosting guard, and a small FIFO of key-press codes.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_t;
    typedef enum logic [1:0] {K_NONE, K_KEY, K_MULTI} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [3:0] idx;
    } cand_t;

    localparam cand_t CAND_NONE = '{kind: K_NONE, idx: 4'h0};

    // Hex label of the key at matrix index 4*col+row.
    function automatic logic [3:0] key_label(input logic [3:0] idx);
        case (idx)
            4'd0:    key_label = 4'h1;
            4'd1:    key_label = 4'h4;
            4'd2:    key_label = 4'h7;
            4'd3:    key_label = 4'h0;
            4'd4:    key_label = 4'h2;
            4'd5:    key_label = 4'h5;
            4'd6:    key_label = 4'h8;
            4'd7:    key_label = 4'hF;
            4'd8:    key_label = 4'h3;
            4'd9:    key_label = 4'h6;
            4'd10:   key_label = 4'h9;
            4'd11:   key_label = 4'hE;
            4'd12:   key_label = 4'hA;
            4'd13:   key_label = 4'hB;
            4'd14:   key_label = 4'hC;
            default: key_label = 4'hD;
        endcase
    endfunction

    // Stable-scan counter increment that saturates at the debounce target.
    function automatic logic [STB_W-1:0] sat_inc(input logic [STB_W-1:0] v);
        if (v == STB_W'(DEBOUNCE_SCANS))
            sat_inc = v;
        else
            sat_inc = v + STB_W'(1);
    endfunction

    col_t             state;
    logic [CNT_W-1:0] dwell;
    logic [3:0]       row_p0, row_p1;
    logic [15:0]      raw, raw_next;
    logic             sample, scan_done;

    cand_t            cand, prev_cand, deb;
    logic [STB_W-1:0] stable, stable_nx;
    logic [4:0]       ones;
    logic [3:0]       one_idx;
    logic             accept, press;

    logic [3:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             empty, full, pop, push_ok, drop;

    assign sample    = (dwell == CNT_W'(SCAN_DIV - 1));
    assign scan_done = sample && (state == COL3);

    // Two-flop synchroniser on the asynchronous rows; inverted so 1 = pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0 <= 4'h0;
            row_p1 <= 4'h0;
        end else begin
            row_p0 <= ~kp.i_row;
            row_p1 <= row_p0;
        end
    end

    // Column strobe FSM: dwell SCAN_DIV cycles per column, then advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COL0;
            dwell    <= '0;
            kp.o_col <= 4'b1110;
        end else if (sample) begin
            dwell <= '0;
            case (state)
                COL0:    begin state <= COL1; kp.o_col <= 4'b1101; end
                COL1:    begin state <= COL2; kp.o_col <= 4'b1011; end
                COL2:    begin state <= COL3; kp.o_col <= 4'b0111; end
                default: begin state <= COL0; kp.o_col <= 4'b1110; end
            endcase
        end else begin
            dwell <= dwell + CNT_W'(1);
        end
    end

    // Raw map including the column being sampled this cycle.
    always_comb begin
        raw_next = raw;
        if (sample)
            raw_next[{state, 2'b00} +: 4] = row_p1;
    end

    // Raw map register, written one column slice per dwell period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            raw <= 16'h0;
        else
            raw <= raw_next;
    end

    // Classify the completed scan as no key, one key, or several keys.
    always_comb begin
        ones    = 5'd0;
        one_idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (raw_next[i]) begin
                ones    = ones + 5'd1;
                one_idx = 4'(i);
            end
        end
        cand = CAND_NONE;
        if (ones == 5'd1)
            cand = '{kind: K_KEY, idx: one_idx};
        else if (ones != 5'd0)
            cand = '{kind: K_MULTI, idx: 4'h0};
    end

    // Debounce decision: accept after enough identical scans; only a new key is a press.
    always_comb begin
        stable_nx = (cand == prev_cand) ? sat_inc(stable) : STB_W'(1);
        accept    = scan_done && (stable_nx == STB_W'(DEBOUNCE_SCANS)) && (cand != deb);
        press     = accept && (cand.kind == K_KEY);
    end

    // Debounce state, updated once per full scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cand <= CAND_NONE;
            deb       <= CAND_NONE;
            stable    <= '0;
        end else if (scan_done) begin
            prev_cand <= cand;
            stable    <= stable_nx;
            if (accept)
                deb <= cand;
        end
    end

    assign kp.o_key_pressed = (deb.kind == K_KEY);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = kp.o_key_valid && kp.i_key_ready;
    assign push_ok = press && (!full || pop);
    assign drop    = press && full && !pop;

    assign kp.o_key_valid = !empty;
    assign kp.o_key_code  = empty ? 4'h0 : mem[rd_ptr[PTR_W-1:0]];

    // FIFO storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[PTR_W-1:0]] <= key_label(cand.idx);
    end

    // FIFO pointers and sticky overflow flag (a set beats a clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            kp.o_overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (drop)
                kp.o_overflow <= 1'b1;
            else if (kp.i_clr_overflow)
                kp.o_overflow <= 1'b0;
        end
    end
endmodule
